elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
- Parametrised, handshaked successor to the fixed fetch/decode/execute/memory/writeback boundary registers.
- One generic stage register replaces all of them: configurable payload width, an optional skid entry for full throughput with a registered in_ready, and a synchronous flush for branch/jump squash.
- Sits between any two pipeline stages. The upstream stage drives in_*, the downstream stage consumes out_*, and the hazard unit drives flush and observes occupancy.

Parameters:
- WIDTH, 32: payload width in bits (packed control plus data bundle of a stage).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- RESET_VALUE, 0: value of both data entries and out_data after reset or flush; WIDTH bits, zero-extended.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  register can accept; transfer when in_valid && in_ready (in_fire).
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready (out_fire). Low = stall.
- out_data  out  WIDTH  payload presented downstream (main entry).
- flush  in  1  synchronous squash of all held entries.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- Reset (asynchronous on rst high):
  - State EMPTY.
  - Main and skid entries set to RESET_VALUE.
  - out_valid=0, occupancy=0, out_data=RESET_VALUE.
  - in_ready=1.
- Latency: 1 cycle from in_fire to out_valid in EMPTY.
- Throughput: 1 payload/cycle when out_ready is held high, for both SKID values.
- States when SKID=1: EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, main + skid valid).
  - EMPTY: in_fire -> BUSY, main<=in_data.
  - BUSY, in_fire && out_fire -> BUSY, main<=in_data.
  - BUSY, in_fire && !out_fire -> FULL, skid<=in_data, main unchanged.
  - BUSY, !in_fire && out_fire -> EMPTY.
  - FULL: out_fire -> BUSY, main<=skid. in_fire cannot occur because in_ready=0.
- in_ready when SKID=1: a flop, equal to (next state != FULL). It never depends combinationally on out_ready.
- States when SKID=0: EMPTY and BUSY only; skid entry absent.
  - in_ready = !out_valid || out_ready (combinational).
  - BUSY, in_fire && out_fire -> BUSY, main<=in_data.
- Flush (sampled at the clock edge):
  - Next state EMPTY; entries set to RESET_VALUE; occupancy 0.
  - Takes priority over in_fire and out_fire in the same cycle.
  - A payload presented in the flush cycle is discarded, even if in_ready=1.
  - An out_fire in the flush cycle still counts as delivered downstream; that is the consumer's responsibility.
  - in_ready=1 in the cycle after flush.
- Stability: while out_valid && !out_ready, out_data and out_valid hold. Payload order is strictly FIFO, with no loss or duplication.
- in_valid must not be withdrawn by upstream before in_fire; the block does not check this.
- occupancy: registered, equals state encoding, saturates at 1 when SKID=0.
- No X propagation: unused skid bits are still reset.
- rst asserted mid-transfer drops all entries immediately (asynchronous). No output glitch to valid=1 is permitted.

Test Plan:
- Reset then stream with SKID=1: hold rst 3 cycles, release, present in_data 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data 0x11,0x22,0x33 on cycles 1,2,3 after the first in_fire; occupancy stays 1; in_ready always 1.
- Stall into skid: BUSY holding 0xA, out_ready=0, present 0xB -> FULL, occupancy=2, in_ready=0 the next cycle, out_data stays 0xA. Raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1.
- Flush collision: FULL holding 0xA/0xB, assert flush with out_ready=0 and in_valid=1 carrying 0xC -> next cycle out_valid=0, occupancy=0, out_data=RESET_VALUE, in_ready=1, and 0xC never appears.
- SKID=0 back-pressure: BUSY holding 0x5, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 carrying 0x6 -> out_data becomes 0x6 the next cycle, 0x5 consumed once.
- Async reset mid-stream: assert rst between clock edges while FULL -> out_valid=0 and occupancy=0 before the next rising edge, in_ready=1.
- Random soak (both SKID values, WIDTH=64): random in_valid/out_ready/flush over 10k cycles -> scoreboard shows in-order delivery, with the only losses being entries squashed by flush.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Generic handshaked pipeline stage register: one main entry, an optional skid
// entry for full throughput behind a registered in_ready, and a synchronous flush.
module elastic_pipe_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SKID        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT            state, nextState;
  logic [WIDTH-1:0] mainData, skidData;
  logic [WIDTH-1:0] nextMain, nextSkid;
  logic             inReadyReg;
  logic             inFire, outFire;

  assign out_valid = (state != EMPTY);
  assign out_data  = mainData;
  assign occupancy = state;

  // With a skid entry, in_ready comes straight from a flop so it never sees out_ready.
  assign in_ready = (SKID != 0) ? inReadyReg : (!out_valid || out_ready);

  assign inFire  = in_valid && in_ready;
  assign outFire = out_valid && out_ready;

  always_comb begin
    nextState = state;
    nextMain  = mainData;
    nextSkid  = skidData;
    if (flush) begin
      nextState = EMPTY;
      nextMain  = RESET_VALUE;
      nextSkid  = RESET_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            nextState = BUSY;
            nextMain  = in_data;
          end
        end
        BUSY: begin
          if (inFire && outFire) begin
            nextMain = in_data;
          end else if (inFire) begin
            if (SKID != 0) begin
              nextState = FULL;
              nextSkid  = in_data;
            end
          end else if (outFire) begin
            nextState = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            nextState = BUSY;
            nextMain  = skidData;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      mainData   <= RESET_VALUE;
      skidData   <= RESET_VALUE;
      inReadyReg <= 1'b1;
    end else begin
      state      <= nextState;
      mainData   <= nextMain;
      skidData   <= nextSkid;
      inReadyReg <= (nextState != FULL);
    end
  end

endmodule
